// File: rtl/pipe_pkg.sv
// Shared helpers for the elastic pipeline chain: width math and stage indices.
package pipe_pkg;

  localparam int unsigned STAGE_IN = 0;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    for (int unsigned v = 1; v < value; v = v << 1) begin
      r = r + 1;
    end
    return r;
  endfunction

  // Bits needed to count every entry the chain can hold, including zero.
  function automatic int unsigned occ_width(input int unsigned depth, input int unsigned skid);
    return clog2(depth * (1 + skid) + 1);
  endfunction

  function automatic int unsigned stage_out(input int unsigned depth);
    return depth - 1;
  endfunction

endpackage

// File: rtl/pipe_stage_elastic.sv
// One elastic stage: main register plus optional skid register under valid/ready,
// with a flush that kills held items but still accepts an incoming one.
module pipe_stage_elastic #(
  parameter int unsigned           WIDTH     = 32,
  parameter int unsigned           SKID      = 1,
  parameter logic [WIDTH-1:0]      RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             up_valid,
  output logic             up_ready,
  input  logic [WIDTH-1:0] up_data,
  output logic             dn_valid,
  input  logic             dn_ready,
  output logic [WIDTH-1:0] dn_data,
  output logic [1:0]       count
);

  logic             main_v;
  logic [WIDTH-1:0] main_d;
  logic             up_fire;
  logic             dn_fire;

  // A flushed stage presents nothing downstream, so no item leaves it this cycle.
  assign dn_valid = main_v & ~flush;
  assign dn_data  = main_d;
  assign up_fire  = up_valid & up_ready;
  assign dn_fire  = dn_valid & dn_ready;

  if (SKID != 0) begin : g_skid
    logic             skid_v;
    logic [WIDTH-1:0] skid_d;

    assign up_ready = ~skid_v;
    assign count    = {1'b0, main_v} + {1'b0, skid_v};

    always_ff @(posedge clk) begin
      if (rst) begin
        main_v <= 1'b0;
        skid_v <= 1'b0;
        main_d <= RESET_VAL;
        skid_d <= RESET_VAL;
      end else if (flush) begin
        main_v <= up_fire;
        skid_v <= 1'b0;
        if (up_fire) main_d <= up_data;
      end else if (dn_fire && skid_v) begin
        main_d <= skid_d;
        skid_v <= 1'b0;
      end else if (dn_fire) begin
        main_v <= up_fire;
        if (up_fire) main_d <= up_data;
      end else if (up_fire && !main_v) begin
        main_v <= 1'b1;
        main_d <= up_data;
      end else if (up_fire) begin
        skid_v <= 1'b1;
        skid_d <= up_data;
      end
    end
  end else begin : g_noskid
    // Ready ripples combinationally from the output back through every stage.
    assign up_ready = ~main_v | dn_ready;
    assign count    = {1'b0, main_v};

    always_ff @(posedge clk) begin
      if (rst) begin
        main_v <= 1'b0;
        main_d <= RESET_VAL;
      end else if (up_fire) begin
        main_v <= 1'b1;
        main_d <= up_data;
      end else if (dn_fire || flush) begin
        main_v <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/pipe_chain_elastic.sv
// Chain of DEPTH elastic stages with per-stage flush and a registered occupancy count.
module pipe_chain_elastic
  import pipe_pkg::*;
#(
  parameter int unsigned      WIDTH     = 32,
  parameter int unsigned      DEPTH     = 3,
  parameter int unsigned      SKID      = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  localparam int unsigned     OCC_W     = occ_width(DEPTH, SKID)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  input  logic [DEPTH-1:0] flush,
  output logic [OCC_W-1:0] occupancy
);

  localparam int unsigned LAST = stage_out(DEPTH);

  logic [1:0]       stage_cnt [DEPTH];
  logic [OCC_W-1:0] killed;
  logic             in_fire;
  logic             out_fire;

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic             up_v;
    logic             up_r;
    logic [WIDTH-1:0] up_d;
    logic             dn_v;
    logic             dn_r;
    logic [WIDTH-1:0] dn_d;

    if (i == STAGE_IN) begin : g_head
      assign up_v = in_valid;
      assign up_d = in_data;
    end else begin : g_link
      assign up_v = g_stage[i-1].dn_v;
      assign up_d = g_stage[i-1].dn_d;
    end

    if (i == LAST) begin : g_tail
      assign dn_r = out_ready;
    end else begin : g_mid
      assign dn_r = g_stage[i+1].up_r;
    end

    pipe_stage_elastic #(
      .WIDTH     (WIDTH),
      .SKID      (SKID),
      .RESET_VAL (RESET_VAL)
    ) u_stage (
      .clk      (clk),
      .rst      (rst),
      .flush    (flush[i]),
      .up_valid (up_v),
      .up_ready (up_r),
      .up_data  (up_d),
      .dn_valid (dn_v),
      .dn_ready (dn_r),
      .dn_data  (dn_d),
      .count    (stage_cnt[i])
    );
  end

  // Handshake is held off at both ends while reset is asserted.
  assign in_ready  = g_stage[STAGE_IN].up_r & ~rst;
  assign out_valid = g_stage[LAST].dn_v & ~rst;
  assign out_data  = g_stage[LAST].dn_d;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  always_comb begin
    killed = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (flush[i]) killed = killed + OCC_W'(stage_cnt[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      occupancy <= '0;
    end else begin
      occupancy <= occupancy + OCC_W'(in_fire) - OCC_W'(out_fire) - killed;
    end
  end

endmodule
